// File: rtl/mux8_sweep_ctrl.sv
// Self-test sequencer for mux8_impl: drives all eight {a,b,c} vectors, samples y, records mismatches.
// Optional MUX8_SWEEP_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
module mux8_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] expected_tt,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_mask,
    output logic [3:0] err_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state, state_nx;
    logic [2:0] idx, idx_nx;
    logic [3:0] cnt, cnt_nx;
    logic [7:0] tt, tt_nx;
    logic [7:0] mask_nx;
    logic [3:0] count_nx;
    logic       pass_nx;
    logic       mismatch;
    logic [2:0] abc_nx;
    logic       busy_nx;
    logic       done_nx;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        tt_nx    = tt;
        mask_nx  = err_mask;
        count_nx = err_count;
        pass_nx  = pass;
        mismatch = (y != tt[idx]);

        case (state)
            IDLE: begin
                if (start) begin
                    tt_nx    = expected_tt;
                    mask_nx  = '0;
                    count_nx = '0;
                    pass_nx  = 1'b0;
                    idx_nx   = '0;
                    cnt_nx   = SETTLE_LOAD;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) state_nx = SAMPLE;
            end
            SAMPLE: begin
                if (mismatch) begin
                    mask_nx[idx] = 1'b1;
                    count_nx     = err_count + 4'd1;
                end
`ifdef MUX8_SWEEP_STOP_ON_ERR_EN
                if (idx == 3'd7 || mismatch) begin
`else
                if (idx == 3'd7) begin
`endif
                    state_nx = DONE;
                end else begin
                    idx_nx   = idx + 3'd1;
                    cnt_nx   = SETTLE_LOAD;
                    state_nx = SETTLE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next-state values.
        if (state_nx == DONE) pass_nx = (mask_nx == '0);
        abc_nx  = (state_nx == IDLE) ? '0 : idx_nx;
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            tt        <= '0;
            err_mask  <= '0;
            err_count <= '0;
            pass      <= 1'b0;
            {a, b, c} <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            cnt       <= cnt_nx;
            tt        <= tt_nx;
            err_mask  <= mask_nx;
            err_count <= count_nx;
            pass      <= pass_nx;
            {a, b, c} <= abc_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_mux8_sweep_ctrl.sv
// Directed bench for mux8_sweep_ctrl with a behavioural mux8_impl stand-in (truth table 8'h39).
module tb_mux8_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] expected_tt = 8'h39;
    logic       y;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [7:0] err_mask;
    logic [3:0] err_count;

    logic [7:0] good_tt = 8'h39;
    logic       stuck = 1'b0;
    int         passed = 0;
    int         total = 0;

    always #5 clk = ~clk;

    assign y = stuck ? 1'b0 : good_tt[{a, b, c}];

    mux8_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .expected_tt(expected_tt), .y(y),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .err_mask(err_mask), .err_count(err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Starts a sweep from IDLE and follows it through DONE and back to IDLE.
    task automatic run_sweep(input string tag, input logic [7:0] emask, input logic [3:0] ecount,
                             input logic epass, input int edone, input int chg_cyc, input int pulse_cyc);
        int cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            if (cyc == chg_cyc) expected_tt = 8'hFF;
            start = (cyc == pulse_cyc);
            chk({tag, "_abc"}, 8'({a, b, c}), 8'((cyc - 1) / 3));
            tick();
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, 8'(cyc), 8'(edone));
        chk({tag, "_busy_in_done"}, 8'(busy), 8'd1);
        chk({tag, "_mask"}, err_mask, emask);
        chk({tag, "_count"}, 8'(err_count), 8'(ecount));
        chk({tag, "_pass"}, 8'(pass), 8'(epass));
        tick();
        chk({tag, "_done_pulse_end"}, 8'(done), 8'd0);
        chk({tag, "_busy_fall"}, 8'(busy), 8'd0);
        chk({tag, "_abc_idle"}, 8'({a, b, c}), 8'd0);
        chk({tag, "_mask_hold"}, err_mask, emask);
        expected_tt = 8'h39;
    endtask

    initial begin
        int cyc;
        int ndone;
        int dcyc;

        // Reset held for two cycles
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_pass", 8'(pass), 8'd0);
        chk("rst_mask", err_mask, 8'h00);
        chk("rst_count", 8'(err_count), 8'd0);
        chk("rst_abc", 8'({a, b, c}), 8'd0);
        reset_n = 1'b1;
        tick();

        run_sweep("good", 8'h00, 4'd0, 1'b1, 25, 0, 0);

        stuck = 1'b1;
`ifdef MUX8_SWEEP_STOP_ON_ERR_EN
        run_sweep("stuck0", 8'h01, 4'd1, 1'b0, 4, 0, 0);
`else
        run_sweep("stuck0", 8'h39, 4'd4, 1'b0, 25, 0, 0);
`endif
        stuck = 1'b0;

        // Start pulse in SETTLE and expected_tt change at idx 3 must not disturb the sweep
        run_sweep("disturb", 8'h00, 4'd0, 1'b1, 25, 10, 2);

        // Start held high for 40 cycles
        start = 1'b1;
        tick();
        cyc = 1;
        ndone = 0;
        dcyc = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                ndone++;
                if (dcyc == 0) dcyc = cyc;
            end
            if (cyc == 26) chk("held_idle_busy", 8'(busy), 8'd0);
            if (cyc == 27) chk("held_restart_busy", 8'(busy), 8'd1);
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("held_done_count", 8'(ndone), 8'd1);
        chk("held_done_cycle", 8'(dcyc), 8'd25);
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("held_second_done_cycle", 8'(cyc), 8'd51);
        chk("held_second_pass", 8'(pass), 8'd1);
        tick();

        // Reset in the middle of the sweep, at idx 4
        stuck = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
`ifdef MUX8_SWEEP_STOP_ON_ERR_EN
        chk("midrst_pre_mask", err_mask, 8'h01);
`else
        chk("midrst_pre_abc", 8'({a, b, c}), 8'd4);
        chk("midrst_pre_mask", err_mask, 8'h09);
        chk("midrst_pre_count", 8'(err_count), 8'd2);
`endif
        reset_n = 1'b0;
        tick();
        chk("midrst_busy", 8'(busy), 8'd0);
        chk("midrst_done", 8'(done), 8'd0);
        chk("midrst_pass", 8'(pass), 8'd0);
        chk("midrst_mask", err_mask, 8'h00);
        chk("midrst_count", 8'(err_count), 8'd0);
        chk("midrst_abc", 8'({a, b, c}), 8'd0);
        reset_n = 1'b1;
        stuck = 1'b0;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        chk("midrst_no_done", 8'(ndone), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
